// File: rtl/nibble_deser_frame_rx.sv
// Receive-path deserializer: packs IN_W-bit beats into OUT_W-bit words while ena gates a frame,
// checks the first word against PREAMBLE and forwards/counts the payload words.
module nibble_deser_frame_rx #(
    parameter int                     IN_W      = 4,
    parameter int                     RATIO     = 2,
    parameter logic [IN_W*RATIO-1:0]  PREAMBLE  = 8'h55,
    parameter int                     CNT_W     = 10,
    parameter bit                     MSB_FIRST = 1'b0,
    localparam int                    OUT_W     = IN_W*RATIO
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ena,
    input  logic [IN_W-1:0]  datain,
    output logic [OUT_W-1:0] dataout,
    output logic             dout_valid,
    output logic [CNT_W-1:0] word_cnt,
    output logic             error_pzdc,
    output logic             frame_done,
    output logic             frame_partial
);

    localparam int SLOT_W = $clog2(RATIO);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(RATIO - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [OUT_W-1:0]   shreg_q, shreg_d;
    logic [OUT_W-1:0]   dataout_q, dataout_d;
    logic               dout_valid_q, dout_valid_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic               error_q, error_d;
    logic               done_q, done_d;
    logic               partial_q, partial_d;
    logic [OUT_W-1:0]   word_s;

    // Drops beat b into the lane owned by slot s; MSB_FIRST mirrors the lane order.
    function automatic logic [OUT_W-1:0] insert_beat(input logic [OUT_W-1:0] w,
                                                     input logic [IN_W-1:0]  b,
                                                     input logic [SLOT_W-1:0] s);
        logic [OUT_W-1:0] r;
        int pos;
        r   = w;
        pos = MSB_FIRST ? (RATIO - 1 - int'(s)) : int'(s);
        for (int k = 0; k < RATIO; k++) begin
            if (k == pos) begin
                r[k*IN_W +: IN_W] = b;
            end else begin
                r[k*IN_W +: IN_W] = w[k*IN_W +: IN_W];
            end
        end
        return r;
    endfunction

    // Next-state and output computation for the frame receiver.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        shreg_d      = shreg_q;
        dataout_d    = dataout_q;
        dout_valid_d = 1'b0;
        word_cnt_d   = word_cnt_q;
        error_d      = error_q;
        done_d       = 1'b0;
        partial_d    = 1'b0;
        word_s       = insert_beat(shreg_q, datain, slot_q);

        if (!ena) begin
            state_d    = ST_IDLE;
            slot_d     = '0;
            shreg_d    = '0;
            word_cnt_d = '0;
            error_d    = 1'b0;
            if (state_q == ST_DATA) begin
                done_d    = 1'b1;
                partial_d = (slot_q != '0);
            end else begin
                done_d    = 1'b0;
                partial_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    shreg_d = insert_beat({OUT_W{1'b0}}, datain, {SLOT_W{1'b0}});
                    slot_d  = SLOT_W'(1);
                    state_d = ST_PRE;
                end
                ST_PRE: begin
                    shreg_d = word_s;
                    if (slot_q == SLOT_LAST) begin
                        slot_d = '0;
                        if (word_s == PREAMBLE) begin
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_ERR;
                            error_d = 1'b1;
                        end
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
                ST_DATA: begin
                    shreg_d = word_s;
                    if (slot_q == SLOT_LAST) begin
                        slot_d       = '0;
                        dataout_d    = word_s;
                        dout_valid_d = 1'b1;
                        if (word_cnt_q != {CNT_W{1'b1}}) begin
                            word_cnt_d = word_cnt_q + CNT_W'(1);
                        end else begin
                            word_cnt_d = word_cnt_q;
                        end
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
                ST_ERR: begin
                    state_d = ST_ERR;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            slot_q       <= '0;
            shreg_q      <= '0;
            dataout_q    <= '0;
            dout_valid_q <= 1'b0;
            word_cnt_q   <= '0;
            error_q      <= 1'b0;
            done_q       <= 1'b0;
            partial_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            shreg_q      <= shreg_d;
            dataout_q    <= dataout_d;
            dout_valid_q <= dout_valid_d;
            word_cnt_q   <= word_cnt_d;
            error_q      <= error_d;
            done_q       <= done_d;
            partial_q    <= partial_d;
        end
    end

    assign dataout       = dataout_q;
    assign dout_valid    = dout_valid_q;
    assign word_cnt      = word_cnt_q;
    assign error_pzdc    = error_q;
    assign frame_done    = done_q;
    assign frame_partial = partial_q;

endmodule

// File: tb/tb_nibble_deser_frame_rx.sv
// Bench for nibble_deser_frame_rx: three configurations run side by side against a
// beat-counting reference model; directed frames first, then randomized traffic.
module tb_nibble_deser_frame_rx;

    localparam int ND = 3;
    localparam int CFG_RATIO [ND] = '{2, 4, 2};
    localparam int CFG_MSB   [ND] = '{0, 1, 0};
    localparam int CFG_PRE   [ND] = '{32'h55, 32'h5555, 32'h55};
    localparam int CFG_CNTW  [ND] = '{10, 10, 3};

    logic            clock = 1'b0;
    logic [ND-1:0]   rstn;
    logic [ND-1:0]   ena;
    logic [3:0]      din [ND];
    logic [7:0]      dout0, dout2;
    logic [15:0]     dout1;
    logic [9:0]      cnt0, cnt1;
    logic [2:0]      cnt2;
    logic [ND-1:0]   vld, err, done, part;
    logic [63:0]     o_dout [ND];
    logic [63:0]     o_cnt  [ND];

    int n_vec = 0;
    int n_err = 0;
    int strobes2 = 0;

    int              m_n    [ND];
    bit              m_in   [ND];
    bit              m_good [ND];
    bit              m_err  [ND];
    longint unsigned m_word [ND];
    longint unsigned m_dout [ND];
    longint unsigned m_cnt  [ND];

    always #5 clock = ~clock;

    nibble_deser_frame_rx #(.IN_W(4), .RATIO(2), .PREAMBLE(8'h55), .CNT_W(10), .MSB_FIRST(1'b0)) u_dut0 (
        .clock(clock), .reset_n(rstn[0]), .ena(ena[0]), .datain(din[0]), .dataout(dout0),
        .dout_valid(vld[0]), .word_cnt(cnt0), .error_pzdc(err[0]), .frame_done(done[0]),
        .frame_partial(part[0]));
    nibble_deser_frame_rx #(.IN_W(4), .RATIO(4), .PREAMBLE(16'h5555), .CNT_W(10), .MSB_FIRST(1'b1)) u_dut1 (
        .clock(clock), .reset_n(rstn[1]), .ena(ena[1]), .datain(din[1]), .dataout(dout1),
        .dout_valid(vld[1]), .word_cnt(cnt1), .error_pzdc(err[1]), .frame_done(done[1]),
        .frame_partial(part[1]));
    nibble_deser_frame_rx #(.IN_W(4), .RATIO(2), .PREAMBLE(8'h55), .CNT_W(3), .MSB_FIRST(1'b0)) u_dut2 (
        .clock(clock), .reset_n(rstn[2]), .ena(ena[2]), .datain(din[2]), .dataout(dout2),
        .dout_valid(vld[2]), .word_cnt(cnt2), .error_pzdc(err[2]), .frame_done(done[2]),
        .frame_partial(part[2]));

    assign o_dout[0] = {56'd0, dout0};
    assign o_dout[1] = {48'd0, dout1};
    assign o_dout[2] = {56'd0, dout2};
    assign o_cnt[0]  = {54'd0, cnt0};
    assign o_cnt[1]  = {54'd0, cnt1};
    assign o_cnt[2]  = {61'd0, cnt2};

    task automatic chk(input string tag, input int d, input longint unsigned obs, input longint unsigned exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic drv(input int d, input bit r, input bit e, input int b);
        rstn[d] = r;
        ena[d]  = e;
        din[d]  = 4'(b);
    endtask

    // One clock: advance the frame-level model on the inputs seen at the edge, then compare.
    task automatic cyc();
        @(posedge clock);
        #1;
        for (int d = 0; d < ND; d++) begin
            int r, p, sh;
            bit ev, ed, ep;
            longint unsigned maxc;
            r    = CFG_RATIO[d];
            maxc = (64'd1 << CFG_CNTW[d]) - 64'd1;
            ev = 1'b0; ed = 1'b0; ep = 1'b0;
            if (!rstn[d]) begin
                m_n[d] = 0; m_in[d] = 1'b0; m_good[d] = 1'b0; m_err[d] = 1'b0;
                m_dout[d] = 0; m_cnt[d] = 0;
            end else if (!ena[d]) begin
                if (m_in[d] && m_good[d]) begin
                    ed = 1'b1;
                    ep = (m_n[d] % r) != 0;
                end
                m_n[d] = 0; m_in[d] = 1'b0; m_good[d] = 1'b0; m_err[d] = 1'b0; m_cnt[d] = 0;
            end else begin
                m_in[d] = 1'b1;
                p  = m_n[d] % r;
                sh = CFG_MSB[d] != 0 ? (r - 1 - p) * 4 : p * 4;
                if (p == 0) m_word[d] = 0;
                m_word[d] = m_word[d] | (longint'(din[d]) << sh);
                m_n[d]++;
                if (p == r - 1) begin
                    if (m_n[d] == r) begin
                        m_good[d] = (m_word[d] == longint'(CFG_PRE[d]));
                        m_err[d]  = !m_good[d];
                    end else if (m_good[d]) begin
                        ev = 1'b1;
                        m_dout[d] = m_word[d];
                        if (m_cnt[d] < maxc) m_cnt[d]++;
                    end
                end
            end
            chk("dout_valid", d, 64'(vld[d]), 64'(ev));
            chk("dataout", d, o_dout[d], m_dout[d]);
            chk("word_cnt", d, o_cnt[d], m_cnt[d]);
            chk("error_pzdc", d, 64'(err[d]), 64'(m_err[d]));
            chk("frame_done", d, 64'(done[d]), 64'(ed));
            chk("frame_partial", d, 64'(part[d]), 64'(ep));
        end
        if (vld[2]) strobes2++;
    endtask

    task automatic frame(input int d, input int q[$]);
        foreach (q[i]) begin
            drv(d, 1'b1, 1'b1, q[i]);
            cyc();
        end
        drv(d, 1'b1, 1'b0, 0);
        cyc();
    endtask

    initial begin
        for (int d = 0; d < ND; d++) drv(d, 1'b0, 1'b1, 5);
        cyc();
        cyc();
        for (int d = 0; d < ND; d++) drv(d, 1'b1, 1'b0, 0);
        cyc();

        // Basic frame, preamble error frame, truncated frame on the default configuration.
        frame(0, '{5, 5, 1, 2, 3, 4});
        chk("t1_last_word", 0, o_dout[0], 64'h43);
        frame(0, '{6, 5, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 7, 8});
        frame(0, '{5, 5, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15))});

        // Four-beat MSB-first words.
        frame(1, '{5, 5, 5, 5, 1, 2, 3, 4});
        chk("t4_word", 1, o_dout[1], 64'h1234);

        // Counter saturation with a 3-bit counter: 10 payload words.
        strobes2 = 0;
        drv(2, 1'b1, 1'b1, 5); cyc();
        drv(2, 1'b1, 1'b1, 5); cyc();
        for (int i = 0; i < 20; i++) begin
            drv(2, 1'b1, 1'b1, int'($urandom_range(0, 15)));
            cyc();
        end
        chk("t5_cnt_sat", 2, o_cnt[2], 64'd7);
        chk("t5_strobes", 2, 64'(strobes2), 64'd10);
        drv(2, 1'b1, 1'b0, 0); cyc();

        // Reset in the middle of the second payload word, then a fresh frame straight out of reset.
        drv(0, 1'b1, 1'b1, 5); cyc();
        drv(0, 1'b1, 1'b1, 5); cyc();
        drv(0, 1'b1, 1'b1, 9); cyc();
        drv(0, 1'b1, 1'b1, 10); cyc();
        drv(0, 1'b1, 1'b1, 11); cyc();
        drv(0, 1'b0, 1'b1, 12); cyc();
        chk("t6_rst_dout", 0, o_dout[0], 64'd0);
        frame(0, '{5, 5, 13, 14, 1, 15});
        chk("t6_after_rst", 0, o_dout[0], 64'hf1);

        // Randomized traffic on all three instances with short gaps and rare resets.
        for (int c = 0; c < 1500; c++) begin
            for (int d = 0; d < ND; d++) begin
                bit r, e;
                int b;
                r = ($urandom_range(0, 199) != 0);
                e = ($urandom_range(0, 14) != 0);
                if (m_n[d] < CFG_RATIO[d] && $urandom_range(0, 9) < 8) b = 5;
                else b = int'($urandom_range(0, 15));
                drv(d, r, e, b);
            end
            cyc();
        end
        for (int d = 0; d < ND; d++) drv(d, 1'b1, 1'b0, 0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
